// File: rtl/mod_rx_demod_fifo_if.sv
// Sample stream in, bit FIFO out, for the receive demodulator.
// The bench drives through master; the demodulator sits on slave.
interface mod_rx_demod_fifo_if;
  logic [1:0]        SELMod;
  logic              s_valid;
  logic signed [15:0] s_in;
  logic              sym_start;
  logic              rEN;
  logic              dOut;
  logic              bFull;
  logic              bEmpty;
  logic              bit_valid;
  logic              bit_dec;
  logic              overrun;

  modport master (
    output SELMod, s_valid, s_in, sym_start, rEN,
    input  dOut, bFull, bEmpty, bit_valid, bit_dec, overrun
  );

  modport slave (
    input  SELMod, s_valid, s_in, sym_start, rEN,
    output dOut, bFull, bEmpty, bit_valid, bit_dec, overrun
  );
endinterface

// File: rtl/mod_rx_demod_fifo.sv
// Sign-reference correlator deciding ASK/FSK/PSK bits per symbol,
// feeding a small synchronous bit FIFO drained by a read strobe.
module mod_rx_demod_fifo #(
  parameter int SPS    = 16,
  parameter int THRESH = 4096,
  parameter int DEPTH  = 8
) (
  input logic            CLK,
  input logic            RESET,
  mod_rx_demod_fifo_if.slave bus
);

  localparam int KW    = $clog2(SPS);
  localparam int ACC_W = 16 + KW + 1;
  localparam int AW    = $clog2(DEPTH);

  localparam logic signed [ACC_W-1:0] TH = ACC_W'(THRESH);

  logic [1:0]               sel_q;
  logic [KW-1:0]            k_q;
  logic signed [ACC_W-1:0]  acc_a_q;
  logic signed [ACC_W-1:0]  acc1_q;
  logic signed [ACC_W-1:0]  acc2_q;
  logic                     bv_q;
  logic                     bd_q;

  logic                     chg;
  logic                     idle;
  logic [KW-1:0]            k_cur;
  logic                     last;
  logic                     r1;
  logic                     r2;
  logic signed [ACC_W-1:0]  x;
  logic signed [ACC_W-1:0]  mag;
  logic signed [ACC_W-1:0]  a_n;
  logic signed [ACC_W-1:0]  c1_n;
  logic signed [ACC_W-1:0]  c2_n;
  logic signed [ACC_W-1:0]  ab1;
  logic signed [ACC_W-1:0]  ab2;
  logic                     sel_ask;
  logic                     sel_fsk;
  logic                     sel_psk;
  logic                     dec;

  always_comb begin
    chg   = bus.SELMod != sel_q;
    idle  = bus.SELMod == 2'b11;
    k_cur = bus.sym_start ? '0 : k_q;
    last  = k_cur == KW'(SPS - 1);
    // r1 flips at half symbol, r2 at each quarter
    r1    = ~k_cur[KW-1];
    r2    = ~k_cur[KW-2];
    x     = {{(ACC_W-16){bus.s_in[15]}}, bus.s_in};
    mag   = x[ACC_W-1] ? -x : x;
    a_n   = (bus.sym_start ? '0 : acc_a_q) + mag;
    c1_n  = (bus.sym_start ? '0 : acc1_q) + (r1 ? x : -x);
    c2_n  = (bus.sym_start ? '0 : acc2_q) + (r2 ? x : -x);
    ab1   = c1_n[ACC_W-1] ? -c1_n : c1_n;
    ab2   = c2_n[ACC_W-1] ? -c2_n : c2_n;
  end

  always_comb begin
    sel_ask = bus.SELMod == 2'b00;
    sel_fsk = bus.SELMod == 2'b01;
    sel_psk = bus.SELMod == 2'b10;
    dec     = 1'b0;
    unique case (1'b1)
      sel_ask: dec = a_n >= TH;
      sel_fsk: dec = ab2 > ab1;
      sel_psk: dec = ~c1_n[ACC_W-1];
      default: dec = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sel_q   <= bus.SELMod;
      k_q     <= '0;
      acc_a_q <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      bv_q    <= 1'b0;
      bd_q    <= 1'b0;
    end else begin
      sel_q <= bus.SELMod;
      bv_q  <= 1'b0;
      if (chg || idle) begin
        k_q     <= '0;
        acc_a_q <= '0;
        acc1_q  <= '0;
        acc2_q  <= '0;
      end else if (bus.s_valid) begin
        if (last) begin
          k_q     <= '0;
          acc_a_q <= '0;
          acc1_q  <= '0;
          acc2_q  <= '0;
          bv_q    <= 1'b1;
          bd_q    <= dec;
        end else begin
          k_q     <= k_cur + 1'b1;
          acc_a_q <= a_n;
          acc1_q  <= c1_n;
          acc2_q  <= c2_n;
        end
      end
    end
  end

  logic [AW:0] wp_q;
  logic [AW:0] rp_q;
  logic        mem_q [DEPTH];
  logic        dout_q;
  logic        ov_q;
  logic        empty;
  logic        full;
  logic        wr_en;
  logic        rd_en;

  always_comb begin
    empty = wp_q == rp_q;
    full  = (wp_q[AW] != rp_q[AW]) &&
            (wp_q[AW-1:0] == rp_q[AW-1:0]);
    // a read in the same cycle frees the slot a full write needs
    wr_en = bv_q && (!full || bus.rEN);
    rd_en = bus.rEN && !empty;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= bd_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wp_q   <= '0;
      rp_q   <= '0;
      dout_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (rd_en) begin
        dout_q <= mem_q[rp_q[AW-1:0]];
        rp_q   <= rp_q + 1'b1;
      end
      if (bv_q && !wr_en) ov_q <= 1'b1;
    end
  end

  assign bus.dOut      = dout_q;
  assign bus.bFull     = full;
  assign bus.bEmpty    = empty;
  assign bus.bit_valid = bv_q;
  assign bus.bit_dec   = bd_q;
  assign bus.overrun   = ov_q;

endmodule
